// File: rtl/seq_pattern_detector_if.sv
// Bundle of configuration, serial-data and result signals for seq_pattern_detector.
// The master drives configuration and data; the detector (slave) returns the results.
interface seq_pattern_detector_if #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1),
  parameter int unsigned CNT_W   = 16
);
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               in_valid;
  logic               data_in;
  logic               count_clr;
  logic               detect;
  logic [CNT_W-1:0]   match_count;
  logic               cfg_err;

  modport master (
    output cfg_load, cfg_pattern, cfg_len, cfg_overlap, in_valid, data_in, count_clr,
    input  detect, match_count, cfg_err
  );

  modport slave (
    input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, in_valid, data_in, count_clr,
    output detect, match_count, cfg_err
  );
endinterface

// File: rtl/seq_pattern_detector.sv
// Runtime-programmable serial bit-pattern detector with overlap control,
// input qualification and a saturating match counter.
module seq_pattern_detector #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1),
  parameter int unsigned CNT_W   = 16
) (
  input logic                   clk,
  input logic                   reset,
  seq_pattern_detector_if.slave bus
);

  // Only the newest MAX_LEN-1 bits are kept; the candidate window adds the
  // incoming bit, so the oldest history bit would never be compared.
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               overlap_q, overlap_d;
  logic               err_q, err_d;
  logic               detect_q, detect_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [MAX_LEN-1:0] cand;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W:0]     fill_inc;
  logic               accept;
  logic               match;
  logic               len_bad;

  always_comb begin
    cand = {hist_q, bus.data_in};
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      mask[i] = (i < int'(len_q));
    end
    fill_inc = {1'b0, fill_q} + (LEN_W + 1)'(1);
    accept   = bus.in_valid && !bus.cfg_load && !err_q;
    match    = accept && (fill_inc >= {1'b0, len_q}) &&
               ((cand & mask) == (pattern_q & mask));
    len_bad  = (bus.cfg_len == '0) || (bus.cfg_len > LEN_W'(MAX_LEN));

    hist_d    = hist_q;
    fill_d    = fill_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    err_d     = err_q;
    detect_d  = match;
    count_d   = count_q;

    if (bus.cfg_load) begin
      pattern_d = bus.cfg_pattern;
      len_d     = bus.cfg_len;
      overlap_d = bus.cfg_overlap;
      err_d     = len_bad;
      hist_d    = '0;
      fill_d    = '0;
      detect_d  = 1'b0;
    end else if (accept) begin
      hist_d = cand[MAX_LEN-2:0];
      if (match && !overlap_q) begin
        fill_d = '0;
      end else if (fill_q != LEN_W'(MAX_LEN)) begin
        fill_d = fill_inc[LEN_W-1:0];
      end
    end

    // Clear takes priority over a coincident match; the pulse still goes out.
    if (bus.count_clr) begin
      count_d = '0;
    end else if (match && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q    <= '0;
      fill_q    <= '0;
      pattern_q <= '1;
      len_q     <= LEN_W'(3);
      overlap_q <= 1'b0;
      err_q     <= 1'b0;
      detect_q  <= 1'b0;
      count_q   <= '0;
    end else begin
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      err_q     <= err_d;
      detect_q  <= detect_d;
      count_q   <= count_d;
    end
  end

  assign bus.detect      = detect_q;
  assign bus.match_count = count_q;
  assign bus.cfg_err     = err_q;

endmodule
